// File: rtl/dbus_pkg.sv
// Shared types for the dbus receive path.
package dbus_pkg;

    localparam int DBUS_W = 64;

    typedef enum logic {
        DBUS_RX_IDLE,
        DBUS_RX_BURST
    } dbus_rx_state_e;

    typedef struct packed {
        logic              last;
        logic [DBUS_W-1:0] data;
    } dbus_entry_t;

endpackage

// File: rtl/dbus_rx_fifo.sv
// First-word-fall-through beat buffer for the dbus receiver.
module dbus_rx_fifo
    import dbus_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  dbus_entry_t   wr_entry,
    input  logic          pop,
    output dbus_entry_t   rd_entry,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    dbus_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Head is forced to zero when empty so outputs are defined out of reset.
    assign rd_entry = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/dbus_receiver.sv
// Receive side of the shared dbus: sampling, buffering, back-pressure,
// burst framing and overflow reporting.
module dbus_receiver
    import dbus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DBUS_W-1:0] dbus_data,
    input  logic              dbus_valid,
    input  logic              dbus_last,
    output logic              dbus_stall,
    output logic [DBUS_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              burst_done,
    output logic [LEN_W-1:0]  burst_len,
    output logic              err_ovf,
    input  logic              err_clr
);

    localparam int CW = $clog2(DEPTH + 1);

    dbus_entry_t    wr_entry;
    dbus_entry_t    rd_entry;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    dbus_rx_state_e state;
    dbus_rx_state_e state_n;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_n;
    logic [LEN_W-1:0] len_n;
    logic             done_n;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

    assign push     = dbus_valid & ~dbus_stall;
    assign pop      = rd_valid & rd_ready;
    assign wr_entry = '{last: dbus_last, data: dbus_data};

    dbus_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (rd_entry),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign rd_valid   = ~empty;
    assign rd_data    = rd_entry.data;
    assign rd_last    = rd_entry.last;
    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            dbus_stall <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            dbus_stall <= (count_next == CW'(DEPTH));
            if (err_clr) begin
                err_ovf <= 1'b0;
            end else if (dbus_valid && dbus_stall) begin
                err_ovf <= 1'b1;
            end
        end
    end

    // Dropped beats still frame the burst, so the FSM keys on dbus_valid.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = burst_len;
        done_n  = 1'b0;
        if (dbus_valid) begin
            unique case (state)
                DBUS_RX_IDLE: begin
                    if (dbus_last) begin
                        done_n = 1'b1;
                        len_n  = LEN_W'(1);
                    end else begin
                        state_n = DBUS_RX_BURST;
                        cnt_n   = LEN_W'(1);
                    end
                end
                DBUS_RX_BURST: begin
                    if (dbus_last) begin
                        state_n = DBUS_RX_IDLE;
                        done_n  = 1'b1;
                        len_n   = sat_inc(cnt);
                    end else begin
                        cnt_n = sat_inc(cnt);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DBUS_RX_IDLE;
            cnt        <= '0;
            burst_len  <= '0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            burst_len  <= len_n;
            burst_done <= done_n;
        end
    end

endmodule

// File: tb/tb_dbus_receiver.sv
// Scoreboard bench for dbus_receiver against a queue-based reference model.
module tb_dbus_receiver;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [63:0]      dbus_data = '0;
    logic             dbus_valid = 1'b0;
    logic             dbus_last = 1'b0;
    logic             dbus_stall;
    logic [63:0]      rd_data;
    logic             rd_last;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic             burst_done;
    logic [LEN_W-1:0] burst_len;
    logic             err_ovf;
    logic             err_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_rdy = 0;

    logic [64:0] m_q[$];
    bit          m_stall;
    bit          m_err;
    bit          m_done;
    int          m_len;
    int          m_beats;

    dbus_receiver #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dbus_data  (dbus_data),
        .dbus_valid (dbus_valid),
        .dbus_last  (dbus_last),
        .dbus_stall (dbus_stall),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .burst_done (burst_done),
        .burst_len  (burst_len),
        .err_ovf    (err_ovf),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model and monitor: compare current outputs, then advance the model
    // with the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        bit push;
        bit pop;
        bit old_stall;
        if (!reset) begin
            chk("dbus_stall", dbus_stall, m_stall);
            chk("err_ovf", err_ovf, m_err);
            chk("rd_valid", rd_valid, m_q.size() != 0);
            chk("burst_done", burst_done, m_done);
            chk("burst_len", burst_len, m_len);
            if (rd_valid && rd_ready && m_q.size() != 0) begin
                chk("rd_data", rd_data, m_q[0][63:0]);
                chk("rd_last", rd_last, m_q[0][64]);
            end
        end
        if (reset) begin
            m_q.delete();
            m_stall = 0;
            m_err   = 0;
            m_done  = 0;
            m_len   = 0;
            m_beats = 0;
        end else begin
            old_stall = m_stall;
            push = dbus_valid && !old_stall;
            pop  = rd_ready && m_q.size() != 0;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({dbus_last, dbus_data});
            m_stall = (m_q.size() == DEPTH);
            if (err_clr) m_err = 0;
            else if (dbus_valid && old_stall) m_err = 1;
            m_done = 0;
            if (dbus_valid) begin
                m_beats++;
                if (dbus_last) begin
                    m_done  = 1;
                    m_len   = (m_beats > LEN_MAX) ? LEN_MAX : m_beats;
                    m_beats = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 rd_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic l, input bit obey);
        int w = 0;
        while (obey && dbus_stall && w < 200) begin
            cyc(1);
            w++;
        end
        if (w >= 200) chk("stall_timeout", 1, 0);
        dbus_valid = 1'b1;
        dbus_data  = d;
        dbus_last  = l;
        cyc(1);
        dbus_valid = 1'b0;
        dbus_last  = 1'b0;
    endtask

    initial begin
        int w;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("rst_stall", dbus_stall, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_burst_len", burst_len, 0);
        chk("rst_err_ovf", err_ovf, 0);

        rd_ready = 1'b1;
        drive(64'h0123456789ABCDEF, 1'b1, 1);
        cyc(3);

        rd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) drive(64'(i), i == 4, 1);
        chk("full_stall", dbus_stall, 1);
        drive(64'hDEAD, 1'b1, 0);
        cyc(3);
        chk("ovf_sticky", err_ovf, 1);
        rd_ready = 1'b1;
        cyc(6);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(2);

        for (int i = 0; i < 10; i++) drive(64'h1000 + 64'(i), i == 9, 1);
        cyc(3);
        chk("stream_len", burst_len, 10);

        rd_ready = 1'b0;
        drive(64'hA1, 1'b0, 1);
        drive(64'hA2, 1'b0, 1);
        reset      = 1'b1;
        dbus_valid = 1'b1;
        dbus_data  = 64'hBAD;
        dbus_last  = 1'b1;
        cyc(1);
        reset      = 1'b0;
        dbus_valid = 1'b0;
        dbus_last  = 1'b0;
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_stall", dbus_stall, 0);
        rd_ready = 1'b1;
        drive(64'h55, 1'b1, 1);
        cyc(2);
        chk("post_rst_len", burst_len, 1);

        rand_rdy = 1;
        for (int i = 0; i < 3 * DEPTH; i++)
            drive({$urandom, $urandom}, (i == 3 * DEPTH - 1) ||
                  ($urandom_range(0, 3) == 0), 1);
        for (int i = 0; i < 20; i++) drive({$urandom, $urandom}, i == 19, 1);
        cyc(2);
        chk("sat_len", burst_len, LEN_MAX);
        rand_rdy = 0;
        cyc(1);
        rd_ready = 1'b1;
        w = 0;
        while (m_q.size() != 0 && w < 200) begin
            cyc(1);
            w++;
        end
        chk("drain", m_q.size() == 0, 1);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
